mpsoc_sysid_checker: RTL and testbench

MPSOC_SYSID_CHECKER -- requirements
Module: mpsoc_sysid_checker

---
 rtl/mpsoc_sysid_checker.sv | 88 ++++++++
 tb/tb_mpsoc_sysid_checker.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mpsoc_sysid_checker.sv
// mpsoc_sysid_checker: reads system ID and timestamp words over Avalon-MM and compares them with expected values
module mpsoc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd193,
  parameter logic [31:0] EXPECTED_TS    = 32'd1715517271,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_t;
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);
  state_t      state;
  logic [15:0] wcnt;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= RD_ID;
          wcnt        <= '0;
          avm_address <= 1'b0;
          avm_read    <= 1'b1;
          busy        <= 1'b1;
          id_ok       <= 1'b0;
          ts_ok       <= 1'b0;
          timeout     <= 1'b0;
          id_value    <= '0;
          ts_value    <= '0;
        end
        RD_ID, RD_TS: begin
          // completion is tested first so a last-moment acknowledge beats the timeout
          if (!avm_waitrequest) begin
            if (state == RD_ID) begin
              state       <= RD_TS;
              wcnt        <= '0;
              avm_address <= 1'b1;
              id_value    <= avm_readdata;
              id_ok       <= avm_readdata == EXPECTED_ID;
            end else begin
              state    <= FIN;
              avm_read <= 1'b0;
              done     <= 1'b1;
              ts_value <= avm_readdata;
              ts_ok    <= avm_readdata == EXPECTED_TS;
            end
          end else begin
            wcnt <= wcnt + 16'd1;
            if (wcnt == LIMIT) begin
              state    <= FIN;
              avm_read <= 1'b0;
              done     <= 1'b1;
              timeout  <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpsoc_sysid_checker.sv
// tb_mpsoc_sysid_checker: directed and randomized checks against a cycle-count reference model
module tb_mpsoc_sysid_checker;
  localparam int T = 4;
  localparam logic [31:0] EID = 32'd193;
  localparam logic [31:0] ETS = 32'd1715517271;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  int errors = 0;
  int checks = 0;

  mpsoc_sysid_checker #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One check with s1/s2 stalled cycles on the ID/TS reads; poke re-asserts start while busy.
  task automatic run_check(input logic [31:0] idw, input logic [31:0] tsw,
                           input int s1, input int s2, input bit poke);
    int st[2];
    int done_c, exp_c, a;
    bit id_read, ts_read;
    st[0] = s1;
    st[1] = s2;
    done_c = -1;
    @(negedge clock);
    start = 1'b1;
    avm_waitrequest = 1'b0;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c < 100 && done_c < 0; c++) begin
      @(negedge clock);
      if (c == 1) chk("busy_after_start", busy, 1'b1);
      if (done) done_c = c;
      else begin
        if (poke && c == 2) start = 1'b1;
        a = int'(avm_address);
        avm_waitrequest = avm_read && st[a] > 0;
        avm_readdata = avm_address ? tsw : idw;
        @(posedge clock);
        if (avm_waitrequest) st[a]--;
        #1 start = 1'b0;
      end
    end
    id_read = s1 < T;
    ts_read = id_read && s2 < T;
    exp_c = !id_read ? T + 1 : !ts_read ? s1 + 2 + T : s1 + s2 + 3;
    chk("done_cycle", done_c, exp_c);
    chk("id_ok", id_ok, id_read && idw == EID);
    chk("id_value", id_value, id_read ? idw : 32'd0);
    chk("ts_ok", ts_ok, ts_read && tsw == ETS);
    chk("ts_value", ts_value, ts_read ? tsw : 32'd0);
    chk("timeout", timeout, !ts_read);
    chk("read_in_fin", avm_read, 1'b0);
    avm_waitrequest = 1'b0;
    @(negedge clock);
    chk("done_single_pulse", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("hold_id_value", id_value, id_read ? idw : 32'd0);
  endtask

  initial begin
    int pulses, first, last;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_read", avm_read, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_id_value", id_value, 32'd0);
    chk("rst_ts_value", ts_value, 32'd0);
    reset_n = 1'b1;
    run_check(EID, ETS, 0, 0, 1'b0);
    run_check(32'd194, ETS, 3, 3, 1'b0);
    run_check(EID, ETS, 0, 50, 1'b0);
    run_check(EID, ETS, 3, 0, 1'b0);
    run_check(EID, ETS, 4, 0, 1'b0);
    run_check(EID, ETS, 1, 3, 1'b1);
    for (int i = 0; i < 12; i++)
      run_check($urandom_range(0, 1) ? EID : $urandom, $urandom_range(0, 1) ? ETS : $urandom,
                $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    // asynchronous reset in the middle of a stalled ID read
    @(negedge clock);
    start = 1'b1;
    avm_waitrequest = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_read", avm_read, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_address", avm_address, 1'b0);
    chk("arst_timeout", timeout, 1'b0);
    chk("arst_id_ok", id_ok, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    run_check(EID, ETS, 0, 0, 1'b0);
    // start held high: one check every four cycles
    pulses = 0;
    first = -1;
    last = -1;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      avm_readdata = avm_address ? ETS : EID;
      if (done) begin
        pulses++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clock);
    end
    start = 1'b0;
    chk("b2b_pulses", pulses, 3);
    chk("b2b_first", first, 3);
    chk("b2b_last", last, 11);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      avm_readdata = avm_address ? ETS : EID;
    end
    chk("b2b_idle", busy, 1'b0);
    chk("b2b_id_ok", id_ok, 1'b1);
    chk("b2b_ts_ok", ts_ok, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
